// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, request throttle, tag queue, decode buffer
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]   pc, last_pc;
   logic [31:0]   buf_instr [DEPTH];
   logic [31:0]   buf_pc    [DEPTH];
   logic [31:0]   tag_q     [DEPTH];
   logic [AW-1:0] buf_rd, buf_wr, tag_rd, tag_wr;
   logic [CW-1:0] count, outstanding, drop;
   logic [CW:0]   inflight;
   logic          accept, rsp_keep, pop;
   logic          unused_low_bits;

   assign unused_low_bits = &{1'b0, redirect_pc[1:0]};

   // Throttle counts both buffered and in-flight work so a response always has a slot.
   assign inflight       = {1'b0, outstanding} + {1'b0, count};
   assign imem_req_valid = !rst && !redirect_valid && (inflight < (CW+1)'(DEPTH));
   assign imem_addr      = {pc[31:2], 2'b00};
   assign accept         = imem_req_valid && imem_req_ready;
   assign rsp_keep       = imem_rsp_valid && (drop == '0) && !redirect_valid;
   assign instr_valid    = (count != '0);
   assign pop            = instr_valid && instr_ready && !redirect_valid;
   assign instr          = instr_valid ? buf_instr[buf_rd] : NOP;
   assign instr_pc       = instr_valid ? buf_pc[buf_rd] : last_pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc          <= RESET_PC;
         last_pc     <= RESET_PC;
         count       <= '0;
         outstanding <= '0;
         drop        <= '0;
         buf_rd      <= '0;
         buf_wr      <= '0;
         tag_rd      <= '0;
         tag_wr      <= '0;
      end else if (redirect_valid) begin
         // Everything still in flight after this cycle's response becomes stale.
         pc          <= {redirect_pc[31:2], 2'b00};
         count       <= '0;
         buf_rd      <= '0;
         buf_wr      <= '0;
         tag_rd      <= '0;
         tag_wr      <= '0;
         outstanding <= outstanding - CW'(imem_rsp_valid);
         drop        <= outstanding - CW'(imem_rsp_valid);
      end else begin
         if (accept) begin
            pc     <= pc + 32'd4;
            tag_wr <= tag_wr + 1'b1;
         end
         if (rsp_keep) begin
            buf_wr <= buf_wr + 1'b1;
            tag_rd <= tag_rd + 1'b1;
         end
         if (pop) begin
            buf_rd  <= buf_rd + 1'b1;
            last_pc <= buf_pc[buf_rd];
         end
         if (imem_rsp_valid && (drop != '0))
            drop <= drop - 1'b1;
         count       <= count + CW'(rsp_keep) - CW'(pop);
         outstanding <= outstanding + CW'(accept) - CW'(imem_rsp_valid);
      end
   end

   always_ff @(posedge clk) begin
      if (accept)
         tag_q[tag_wr] <= imem_addr;
      if (rsp_keep) begin
         buf_instr[buf_wr] <= imem_rsp_data;
         buf_pc[buf_wr]    <= tag_q[tag_rd];
      end
   end
endmodule
